mshr_alloc_sched: RTL and testbench
===================================

# mshr_alloc_sched

MSHR allocation scheduler sitting between the two-wide MSHR pre-allocation buffer and up to REQ_NUM miss requesters. It owns the per-entry free vector feeding the pre-allocator, pulls pre-allocated ID pairs into a two-slot staging register, and hands IDs to requesters with round-robin arbitration, up to two grants per cycle. MSHR retirement logic returns IDs through two release ports.

## Interface
- ENTRY_NUM, 32, number of MSHR entries
- ENTRY_ID_WIDTH, $clog2(ENTRY_NUM), ID width
- REQ_NUM, 4, number of requesters (2..8)
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- req_vld  in  REQ_NUM  requester i wants one MSHR ID
- req_rdy  out  REQ_NUM  grant to requester i this cycle
- req_idx  out  REQ_NUM*ENTRY_ID_WIDTH  granted ID, slice i belongs to requester i; valid only with req_rdy[i]
- pa_vld_0 / pa_vld_1  in  1  pre-allocated pair valid (expected equal)
- pa_idx_0 / pa_idx_1  in  ENTRY_ID_WIDTH  pre-allocated IDs
- pa_rdy_0 / pa_rdy_1  out  1  pop pair; always driven identical
- pa_claim_oh  in  ENTRY_NUM  one-hot-or-zero/two-hot IDs the pre-allocator wrote this cycle (its v_in_rdy)
- v_free  out  ENTRY_NUM  1 = entry free and eligible for pre-allocation; drives pre-allocator v_in_vld
- rel_vld_0 / rel_vld_1  in  1  release request
- rel_idx_0 / rel_idx_1  in  ENTRY_ID_WIDTH  released ID
- sched_stall  in  1  suppress all grants this cycle
- err  out  1  sticky protocol error

## Operation
- Free vector: bit clears when pa_claim_oh bit set; bit sets on rel_vld_x for rel_idx_x. Both release ports may fire together (distinct IDs).
- Release of an already-free entry, release of same ID on both ports, claim of a non-free entry, or pa_vld_0 != pa_vld_1: set err; free-vector update still applied (claim clears, release sets). Claim and release of same ID same cycle: release wins, err set.
- Staging: slot0, slot1, each {vld, id}. Pair handshake = pa_vld_0 && pa_vld_1 && pa_rdy_0; loads slot0<=pa_idx_0, slot1<=pa_idx_1, both vld.
- pa_rdy_x = 1 when every valid slot is granted this cycle (includes both slots empty). Combinational from req_vld and sched_stall.
- Grants: G = min(valid slots, 2, requesting count); 0 if sched_stall. Grant 1 goes to first req_vld set at or after rr_ptr (wrapping); grant 2 to next set after grant 1. Grant 1 takes lowest valid slot, grant 2 the remaining slot.
- rr_ptr <= (last granted index + 1) mod REQ_NUM; unchanged when G=0.
- Granted slot vld clears; ungranted slot holds its ID indefinitely (no ID loss).

## Timing
- Reset: v_free all ones, slots invalid, rr_ptr 0, err 0; req_rdy 0 and pa_rdy 1 (empty staging) while outputs combinational from reset state.
- Pair popped in cycle N is grantable in N+1 (one-cycle latency). Pop and drain in same cycle allowed: sustained 2 grants/cycle.
- req_rdy depends on req_vld same cycle; req_vld must not depend on req_rdy.
- Release in cycle N visible on v_free in N+1; claim in N clears v_free in N+1.
- Reset mid-operation discards staged IDs; upstream buffer must be reset together.

## Test plan
- Reset, pair (3,7) presented, req_vld=4'b0101 next cycle -> req0 gets 3, req2 gets 7 same cycle; pa_rdy high that cycle; rr_ptr=3.
- Pair (1,2) staged, only req1 asserts -> req1 gets 1, slot1 keeps 2, pa_rdy low; next cycle req3 asserts -> req3 gets 2, pa_rdy high.
- All four requesters asserting continuously with pairs always available -> grants rotate {0,1},{2,3},{0,1}; 2 IDs/cycle, no ID duplicated or dropped.
- sched_stall high with staged pair and req_vld=4'b1111 -> no req_rdy, no pa_rdy, slots unchanged; stall low -> normal grant.
- pa_claim_oh bit 5, later rel_vld_0 idx 5 -> v_free[5] 0 then 1, err 0; second release of 5 -> err 1 and stays 1 until rst.
- rel 4 on both ports same cycle, or pa_vld_0=1 with pa_vld_1=0 -> err 1; no pair popped in the mismatch case.

Source files
------------

// File: rtl/mshr_alloc_sched_if.sv
// Bundle between the MSHR allocation scheduler, the pair pre-allocator,
// the miss requesters and the MSHR retirement logic.
interface mshr_alloc_sched_if #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_NUM        = 4
);
    logic [REQ_NUM-1:0]                req_vld;
    logic [REQ_NUM-1:0]                req_rdy;
    logic [REQ_NUM*ENTRY_ID_WIDTH-1:0] req_idx;

    logic                      pa_vld_0;
    logic                      pa_vld_1;
    logic [ENTRY_ID_WIDTH-1:0] pa_idx_0;
    logic [ENTRY_ID_WIDTH-1:0] pa_idx_1;
    logic                      pa_rdy_0;
    logic                      pa_rdy_1;
    logic [ENTRY_NUM-1:0]      pa_claim_oh;
    logic [ENTRY_NUM-1:0]      v_free;

    logic                      rel_vld_0;
    logic                      rel_vld_1;
    logic [ENTRY_ID_WIDTH-1:0] rel_idx_0;
    logic [ENTRY_ID_WIDTH-1:0] rel_idx_1;

    logic                      sched_stall;
    logic                      err;

    modport slave (
        input  req_vld, pa_vld_0, pa_vld_1, pa_idx_0, pa_idx_1, pa_claim_oh,
               rel_vld_0, rel_vld_1, rel_idx_0, rel_idx_1, sched_stall,
        output req_rdy, req_idx, pa_rdy_0, pa_rdy_1, v_free, err
    );

    modport master (
        output req_vld, pa_vld_0, pa_vld_1, pa_idx_0, pa_idx_1, pa_claim_oh,
               rel_vld_0, rel_vld_1, rel_idx_0, rel_idx_1, sched_stall,
        input  req_rdy, req_idx, pa_rdy_0, pa_rdy_1, v_free, err
    );
endinterface

// File: rtl/mshr_alloc_sched.sv
// MSHR allocation scheduler: owns the free vector, stages pre-allocated ID
// pairs and hands up to two IDs per cycle to requesters in round-robin order.
module mshr_alloc_sched #(
    parameter int ENTRY_NUM      = 32,
    parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
    parameter int REQ_NUM        = 4
) (
    input  logic                clk,
    input  logic                rst,
    mshr_alloc_sched_if.slave   bus
);
    localparam int RR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [ENTRY_NUM-1:0]      v_free_q, v_free_d;
    logic                      err_q, err_d;
    logic [1:0]                slot_vld_q, slot_vld_d;
    logic [ENTRY_ID_WIDTH-1:0] slot_id_q [2];
    logic [ENTRY_ID_WIDTH-1:0] slot_id_d [2];
    logic [RR_W-1:0]           rr_ptr_q, rr_ptr_d;

    logic [RR_W-1:0]           cand;
    logic                      g1_found, g2_found;
    logic [RR_W-1:0]           g1_idx, g2_idx;
    logic [1:0]                n_slots;
    logic [1:0]                n_grant;
    logic [1:0]                slot_grant;
    logic [ENTRY_ID_WIDTH-1:0] g1_id, g2_id;
    logic                      pa_rdy;
    logic                      pop;
    logic [ENTRY_NUM-1:0]      rel_oh_0, rel_oh_1;

    function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] cur);
        if (int'(cur) == REQ_NUM - 1) return '0;
        return cur + RR_W'(1);
    endfunction

    // Scan requesters starting at rr_ptr; first two hits are grant 1 and 2.
    always_comb begin
        cand     = '0;
        g1_found = 1'b0;
        g2_found = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            cand = RR_W'((int'(rr_ptr_q) + k) % REQ_NUM);
            if (bus.req_vld[cand]) begin
                if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = cand;
                end else if (!g2_found) begin
                    g2_found = 1'b1;
                    g2_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        n_slots = {1'b0, slot_vld_q[0]} + {1'b0, slot_vld_q[1]};
        if (bus.sched_stall || !g1_found || n_slots == 2'd0) begin
            n_grant = 2'd0;
        end else if (g2_found && n_slots == 2'd2) begin
            n_grant = 2'd2;
        end else begin
            n_grant = 2'd1;
        end

        // Grant 1 always takes the lowest valid slot, grant 2 the other one.
        if (n_grant == 2'd0)      slot_grant = 2'b00;
        else if (n_grant == 2'd2) slot_grant = 2'b11;
        else                      slot_grant = slot_vld_q[0] ? 2'b01 : 2'b10;

        g1_id  = slot_vld_q[0] ? slot_id_q[0] : slot_id_q[1];
        g2_id  = slot_id_q[1];
        pa_rdy = (n_grant == n_slots);
        pop    = bus.pa_vld_0 && bus.pa_vld_1 && pa_rdy;
    end

    always_comb begin
        bus.req_rdy = '0;
        bus.req_idx = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (n_grant != 2'd0 && g1_idx == RR_W'(i)) begin
                bus.req_rdy[i] = 1'b1;
                bus.req_idx[i*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH] = g1_id;
            end
            if (n_grant == 2'd2 && g2_idx == RR_W'(i)) begin
                bus.req_rdy[i] = 1'b1;
                bus.req_idx[i*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH] = g2_id;
            end
        end
    end

    assign bus.pa_rdy_0 = pa_rdy;
    assign bus.pa_rdy_1 = pa_rdy;
    assign bus.v_free   = v_free_q;
    assign bus.err      = err_q;

    // A pop refills both slots; it only happens when every held ID drains now.
    always_comb begin
        slot_vld_d   = slot_vld_q & ~slot_grant;
        slot_id_d[0] = slot_id_q[0];
        slot_id_d[1] = slot_id_q[1];
        if (pop) begin
            slot_vld_d   = 2'b11;
            slot_id_d[0] = bus.pa_idx_0;
            slot_id_d[1] = bus.pa_idx_1;
        end

        if (n_grant == 2'd2)      rr_ptr_d = rr_next(g2_idx);
        else if (n_grant == 2'd1) rr_ptr_d = rr_next(g1_idx);
        else                      rr_ptr_d = rr_ptr_q;
    end

    // Releases are applied after claims so a same-cycle release wins.
    always_comb begin
        rel_oh_0 = bus.rel_vld_0 ? (ENTRY_NUM'(1) << bus.rel_idx_0) : '0;
        rel_oh_1 = bus.rel_vld_1 ? (ENTRY_NUM'(1) << bus.rel_idx_1) : '0;
        v_free_d = (v_free_q & ~bus.pa_claim_oh) | rel_oh_0 | rel_oh_1;
        err_d    = err_q
                 | (bus.rel_vld_0 & v_free_q[bus.rel_idx_0])
                 | (bus.rel_vld_1 & v_free_q[bus.rel_idx_1])
                 | (bus.rel_vld_0 & bus.rel_vld_1 & (bus.rel_idx_0 == bus.rel_idx_1))
                 | (|(bus.pa_claim_oh & ~v_free_q))
                 | (|(bus.pa_claim_oh & (rel_oh_0 | rel_oh_1)))
                 | (bus.pa_vld_0 != bus.pa_vld_1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_free_q   <= '1;
            err_q      <= 1'b0;
            slot_vld_q <= 2'b00;
            rr_ptr_q   <= '0;
        end else begin
            v_free_q   <= v_free_d;
            err_q      <= err_d;
            slot_vld_q <= slot_vld_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        slot_id_q[0] <= slot_id_d[0];
        slot_id_q[1] <= slot_id_d[1];
    end
endmodule

// File: tb/tb_mshr_alloc_sched.sv
// Directed bench for mshr_alloc_sched: expected grants go into a queue that a
// negedge monitor drains against req_rdy/req_idx.
module tb_mshr_alloc_sched;
    localparam int EN = 32;
    localparam int IW = 5;
    localparam int RN = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mshr_alloc_sched_if #(.ENTRY_NUM(EN), .ENTRY_ID_WIDTH(IW), .REQ_NUM(RN)) bus ();

    mshr_alloc_sched #(.ENTRY_NUM(EN), .ENTRY_ID_WIDTH(IW), .REQ_NUM(RN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int req;
        int id;
    } gnt_t;

    gnt_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_gnt(input int r, input int id);
        gnt_t g;
        g.req = r;
        g.id  = id;
        exp_q.push_back(g);
    endtask

    task automatic idle();
        bus.req_vld     = '0;
        bus.pa_vld_0    = 1'b0;
        bus.pa_vld_1    = 1'b0;
        bus.pa_idx_0    = '0;
        bus.pa_idx_1    = '0;
        bus.pa_claim_oh = '0;
        bus.rel_vld_0   = 1'b0;
        bus.rel_vld_1   = 1'b0;
        bus.rel_idx_0   = '0;
        bus.rel_idx_1   = '0;
        bus.sched_stall = 1'b0;
    endtask

    task automatic pair(input int a, input int b);
        bus.pa_vld_0 = 1'b1;
        bus.pa_vld_1 = 1'b1;
        bus.pa_idx_0 = IW'(a);
        bus.pa_idx_1 = IW'(b);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every presented grant must match the head of the queue, and
    // anything still queued after a cycle's grants is a missing grant.
    always @(negedge clk) begin
        logic [IW-1:0] got;
        gnt_t e;
        for (int i = 0; i < RN; i++) begin
            if (bus.req_rdy[i] === 1'b1) begin
                got = bus.req_idx[i*IW +: IW];
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL grant_unexpected actual req=%0d id=%0d expected none", i, got);
                end else begin
                    e = exp_q.pop_front();
                    if (e.req != i || int'(got) != e.id) begin
                        bad++;
                        $display("FAIL grant actual req=%0d id=%0d expected req=%0d id=%0d",
                                 i, got, e.req, e.id);
                    end
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL grant_missing actual none expected req=%0d id=%0d", e.req, e.id);
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        bus.req_vld = 4'b1111;
        next_cyc();
        next_cyc();
        mid();
        chk("rst_v_free", bus.v_free, 32'hFFFF_FFFF);
        chk("rst_err", bus.err, 0);
        chk("rst_req_rdy", bus.req_rdy, 0);
        chk("rst_pa_rdy_0", bus.pa_rdy_0, 1);
        chk("rst_pa_rdy_1", bus.pa_rdy_1, 1);
        next_cyc();
        rst = 1'b0;
        idle();

        // Pair (3,7), then requesters 0 and 2.
        pair(3, 7);
        mid();
        chk("popA_pa_rdy", bus.pa_rdy_0, 1);
        next_cyc();
        idle();
        bus.req_vld = 4'b0101;
        expect_gnt(0, 3);
        expect_gnt(2, 7);
        mid();
        chk("t1_pa_rdy", bus.pa_rdy_0, 1);
        next_cyc();

        // Pair (1,2); single requester leaves slot1 held.
        idle();
        pair(1, 2);
        next_cyc();
        idle();
        pair(9, 10);
        bus.req_vld = 4'b0010;
        expect_gnt(1, 1);
        mid();
        chk("t2_partial_pa_rdy", bus.pa_rdy_0, 0);
        next_cyc();
        bus.req_vld = 4'b1000;
        expect_gnt(3, 2);
        mid();
        chk("t2_drain_pa_rdy", bus.pa_rdy_1, 1);
        next_cyc();

        // All requesting, pairs always available.
        pair(11, 12);
        bus.req_vld = 4'b1111;
        expect_gnt(0, 9);
        expect_gnt(1, 10);
        mid();
        chk("t3_pa_rdy_a", bus.pa_rdy_0, 1);
        next_cyc();
        pair(13, 14);
        expect_gnt(2, 11);
        expect_gnt(3, 12);
        next_cyc();
        pair(15, 16);
        expect_gnt(0, 13);
        expect_gnt(1, 14);
        next_cyc();

        // Stall holds everything.
        pair(17, 18);
        bus.sched_stall = 1'b1;
        mid();
        chk("stall_pa_rdy", bus.pa_rdy_0, 0);
        next_cyc();
        bus.sched_stall = 1'b0;
        expect_gnt(2, 15);
        expect_gnt(3, 16);
        mid();
        chk("unstall_pa_rdy", bus.pa_rdy_0, 1);
        next_cyc();
        bus.pa_vld_0 = 1'b0;
        bus.pa_vld_1 = 1'b0;
        expect_gnt(0, 17);
        expect_gnt(1, 18);
        next_cyc();
        idle();

        // Claim then release of entry 5, then a double release.
        bus.pa_claim_oh = 32'h0000_0020;
        next_cyc();
        idle();
        bus.rel_vld_0 = 1'b1;
        bus.rel_idx_0 = 5'd5;
        mid();
        chk("claim5_v_free", bus.v_free, 32'hFFFF_FFDF);
        chk("claim5_err", bus.err, 0);
        next_cyc();
        mid();
        chk("rel5_v_free", bus.v_free, 32'hFFFF_FFFF);
        chk("rel5_err", bus.err, 0);
        next_cyc();
        idle();
        next_cyc();
        mid();
        chk("dbl_rel_err", bus.err, 1);
        next_cyc();
        next_cyc();
        mid();
        chk("err_sticky", bus.err, 1);
        next_cyc();

        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        mid();
        chk("err_cleared", bus.err, 0);
        next_cyc();

        // Same ID released on both ports.
        bus.pa_claim_oh = 32'h0000_0010;
        next_cyc();
        idle();
        bus.rel_vld_0 = 1'b1;
        bus.rel_idx_0 = 5'd4;
        bus.rel_vld_1 = 1'b1;
        bus.rel_idx_1 = 5'd4;
        next_cyc();
        idle();
        mid();
        chk("same_rel_err", bus.err, 1);
        chk("same_rel_v_free", bus.v_free, 32'hFFFF_FFFF);
        next_cyc();

        // pa_vld mismatch: flagged, nothing staged.
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        bus.pa_vld_0 = 1'b1;
        bus.pa_idx_0 = 5'd20;
        bus.pa_idx_1 = 5'd21;
        next_cyc();
        idle();
        bus.req_vld = 4'b1111;
        mid();
        chk("pa_mismatch_err", bus.err, 1);
        chk("pa_mismatch_empty", bus.pa_rdy_0, 1);
        next_cyc();
        idle();

        // Claim and release of the same ID: release wins, error flagged.
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        bus.pa_claim_oh = 32'h0000_0040;
        bus.rel_vld_0   = 1'b1;
        bus.rel_idx_0   = 5'd6;
        next_cyc();
        idle();
        mid();
        chk("clm_rel_v_free", bus.v_free, 32'hFFFF_FFFF);
        chk("clm_rel_err", bus.err, 1);
        next_cyc();
        next_cyc();
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
